// File: rtl/edge_rec_pkg.sv
// Shared edge codes and width helpers for the edge event recorder.
package edge_rec_pkg;

  typedef logic [1:0] edge_t;

  localparam edge_t EDGE_NONE = 2'b00;
  localparam edge_t EDGE_RISE = 2'b01;
  localparam edge_t EDGE_FALL = 2'b10;
  localparam edge_t EDGE_BOTH = 2'b11;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_rec_fifo.sv
// Event record FIFO: count-based full/empty, push and pop allowed on the same edge.
module edge_rec_fifo #(
  parameter int  DEPTH = 8,
  parameter type rec_t = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  rec_t wdata,
  input  logic pop,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  rec_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_r == DEPTH_CNT);
  assign empty = (count_r == '0);
  assign rdata = mem_r[rd_ptr_r];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + 1'b1;
      end else if (do_pop_s && !do_push_s) begin
        count_r <= count_r - 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_event_recorder.sv
// Samples trigger lines, records selected edges with timestamps into a FIFO.
// Optional rising-edge condition checker enabled by EDGE_REC_CHECK_EN.
module edge_event_recorder
  import edge_rec_pkg::*;
#(
  parameter int NTRG  = 4,
  parameter int TS_W  = 6,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NTRG-1:0]          trg,
  input  logic [NTRG-1:0]          en,
  input  logic [NTRG-1:0]          pos_sel,
  input  logic [NTRG-1:0]          neg_sel,
`ifdef EDGE_REC_CHECK_EN
  input  logic [NTRG-1:0]          chk,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          out_ts,
  output logic [idx_w(NTRG)-1:0]   out_idx,
  output logic [1:0]               out_edge,
  output logic [7:0]               drop_cnt,
  output logic                     fail,
  output logic [idx_w(NTRG)-1:0]   fail_idx
);

  localparam int IDX_W = idx_w(NTRG);

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [IDX_W-1:0] idx;
    edge_t            edg;
  } rec_t;

  logic [NTRG-1:0] trg_smp_r;
  logic [NTRG-1:0] trg_dly_r;
  logic [NTRG-1:0] en_smp_r;
  logic            prime_r;
  logic [TS_W-1:0] ts_r;
  logic [7:0]      drop_cnt_r;

  logic [NTRG-1:0] slot_vld_r;
  logic [TS_W-1:0] slot_ts_r   [NTRG];
  edge_t           slot_edge_r [NTRG];

  logic [NTRG-1:0] rise_s, fall_s, evt_s, grant_s, drop_s, load_s;
  edge_t           evt_edge_s [NTRG];
  logic            fifo_full_s, fifo_empty_s, pop_s, can_push_s, push_s;
  rec_t            push_rec_s, head_s;
  logic [3:0]      drop_num_s;
  logic [8:0]      drop_sum_s;
  logic [7:0]      drop_nxt_s;

  // Input sampling; the first sample after reset also fills the delay stage so it cannot look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trg_smp_r <= '0;
      trg_dly_r <= '0;
      en_smp_r  <= '0;
      prime_r   <= 1'b0;
      ts_r      <= '0;
    end else begin
      trg_smp_r <= trg;
      en_smp_r  <= en;
      trg_dly_r <= prime_r ? trg_smp_r : trg;
      prime_r   <= 1'b1;
      ts_r      <= ts_r + 1'b1;
    end
  end

  // Edge detection and edge code per channel.
  always_comb begin
    rise_s = trg_smp_r & ~trg_dly_r;
    fall_s = ~trg_smp_r & trg_dly_r;
    evt_s  = {NTRG{prime_r}} & en_smp_r & ((rise_s & pos_sel) | (fall_s & neg_sel));
    for (int i = 0; i < NTRG; i++) begin
      if (rise_s[i]) begin
        evt_edge_s[i] = neg_sel[i] ? EDGE_BOTH : EDGE_RISE;
      end else begin
        evt_edge_s[i] = EDGE_FALL;
      end
    end
  end

  // Lowest-index pending slot wins the FIFO write; a pop makes room even when full.
  always_comb begin
    pop_s      = out_valid & out_ready;
    can_push_s = ~fifo_full_s | pop_s;
    grant_s    = '0;
    push_s     = 1'b0;
    push_rec_s = '0;
    for (int i = NTRG - 1; i >= 0; i--) begin
      if (slot_vld_r[i] && can_push_s) begin
        grant_s        = '0;
        grant_s[i]     = 1'b1;
        push_s         = 1'b1;
        push_rec_s.ts  = slot_ts_r[i];
        push_rec_s.idx = IDX_W'(i);
        push_rec_s.edg = slot_edge_r[i];
      end else begin
        push_s = push_s;
      end
    end
  end

  // An event only drops when its slot is still occupied after this cycle's grant.
  always_comb begin
    drop_s     = evt_s & slot_vld_r & ~grant_s;
    load_s     = evt_s & ~drop_s;
    drop_num_s = 4'd0;
    for (int i = 0; i < NTRG; i++) begin
      drop_num_s = drop_num_s + {3'd0, drop_s[i]};
    end
    drop_sum_s = {1'b0, drop_cnt_r} + {5'd0, drop_num_s};
    if (drop_sum_s > 9'd255) begin
      drop_nxt_s = 8'hFF;
    end else begin
      drop_nxt_s = drop_sum_s[7:0];
    end
  end

  // Pending slots and the saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_r <= '0;
      for (int i = 0; i < NTRG; i++) begin
        slot_ts_r[i]   <= '0;
        slot_edge_r[i] <= EDGE_NONE;
      end
      drop_cnt_r <= 8'd0;
    end else begin
      for (int i = 0; i < NTRG; i++) begin
        if (load_s[i]) begin
          slot_vld_r[i]  <= 1'b1;
          slot_ts_r[i]   <= ts_r;
          slot_edge_r[i] <= evt_edge_s[i];
        end else if (grant_s[i]) begin
          slot_vld_r[i] <= 1'b0;
        end
      end
      drop_cnt_r <= drop_nxt_s;
    end
  end

  edge_rec_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (push_rec_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign out_valid = ~fifo_empty_s;
  assign out_ts    = head_s.ts;
  assign out_idx   = head_s.idx;
  assign out_edge  = head_s.edg;
  assign drop_cnt  = drop_cnt_r;

`ifdef EDGE_REC_CHECK_EN
  logic [NTRG-1:0]  chk_smp_r;
  logic [NTRG-1:0]  bad_s;
  logic [IDX_W-1:0] bad_idx_s;
  logic             fail_r;
  logic [IDX_W-1:0] fail_idx_r;

  // Rising-edge events whose condition sample was low; lowest channel reported.
  always_comb begin
    bad_s     = evt_s & rise_s & ~chk_smp_r;
    bad_idx_s = '0;
    for (int i = NTRG - 1; i >= 0; i--) begin
      if (bad_s[i]) begin
        bad_idx_s = IDX_W'(i);
      end else begin
        bad_idx_s = bad_idx_s;
      end
    end
  end

  // Sticky failure flag; the index is captured on the first failure only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_smp_r  <= '0;
      fail_r     <= 1'b0;
      fail_idx_r <= '0;
    end else begin
      chk_smp_r <= chk;
      if (!fail_r && (|bad_s)) begin
        fail_r     <= 1'b1;
        fail_idx_r <= bad_idx_s;
      end
    end
  end

  assign fail     = fail_r;
  assign fail_idx = fail_idx_r;
`else
  assign fail     = 1'b0;
  assign fail_idx = '0;
`endif

endmodule

// File: tb/tb_edge_event_recorder.sv
// Directed self-checking bench for edge_event_recorder (works with or without EDGE_REC_CHECK_EN).
module tb_edge_event_recorder;
  import edge_rec_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] trg, en, pos_sel, neg_sel, chk;
  logic       out_valid, out_ready;
  logic [5:0] out_ts;
  logic [1:0] out_idx, out_edge, fail_idx;
  logic [7:0] drop_cnt;
  logic       fail;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  edge_event_recorder #(.NTRG(4), .TS_W(6), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trg       (trg),
    .en        (en),
    .pos_sel   (pos_sel),
    .neg_sel   (neg_sel),
`ifdef EDGE_REC_CHECK_EN
    .chk       (chk),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ts    (out_ts),
    .out_idx   (out_idx),
    .out_edge  (out_edge),
    .drop_cnt  (drop_cnt),
    .fail      (fail),
    .fail_idx  (fail_idx)
  );

  always #5 clk = ~clk;

  // Reference cycle count: equals the DUT timestamp after each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [5:0] next_ts();
    return 6'((cyc + 1) % 64);
  endfunction

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (out_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    trg = 4'b0001; en = 4'b0001; pos_sel = 4'b0001; neg_sel = 4'b0000;
    chk = 4'b1111; out_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_ts, out_idx, out_edge, drop_cnt, fail, fail_idx} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b ts=%0d idx=%0d e=%b drop=%0d f=%b fi=%0d want all 0",
               out_valid, out_ts, out_idx, out_edge, drop_cnt, fail, fail_idx);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({out_valid, drop_cnt} !== 9'd0) begin
      n_bad++;
      $display("FAIL prime_no_event: got valid=%b drop=%0d want 0 0", out_valid, drop_cnt);
    end
  endtask

  task automatic test_single_rise;
    logic [5:0] t;
    int lat;
    trg[0] = 1'b0;
    @(negedge clk);
    trg[0] = 1'b1;
    t = next_ts();
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
    n_cmp++;
    if (lat != 3) begin
      n_bad++;
      $display("FAIL rise_latency: got %0d cycles want 3", lat);
    end
    n_cmp++;
    if ({out_idx, out_edge, out_ts} !== {2'd0, EDGE_RISE, t}) begin
      n_bad++;
      $display("FAIL rise_entry: got idx=%0d e=%b ts=%0d want 0 01 %0d", out_idx, out_edge, out_ts, t);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rise_only_one: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_pulse_both;
    logic [5:0] t1, t2, g1, g2;
    bit ok;
    en = 4'b0010; pos_sel = 4'b0010; neg_sel = 4'b0010;
    @(negedge clk);
    trg[1] = 1'b1; t1 = next_ts();
    repeat (3) @(negedge clk);
    trg[1] = 1'b0; t2 = next_ts();
    wait_valid(ok);
    g1 = out_ts;
    n_cmp++;
    if (!ok || {out_idx, out_edge, out_ts} !== {2'd1, EDGE_BOTH, t1}) begin
      n_bad++;
      $display("FAIL pulse_rise: got ok=%0d idx=%0d e=%b ts=%0d want 1 11 %0d", ok, out_idx, out_edge, out_ts, t1);
    end
    @(negedge clk);
    wait_valid(ok);
    g2 = out_ts;
    n_cmp++;
    if (!ok || {out_idx, out_edge, out_ts} !== {2'd1, EDGE_FALL, t2}) begin
      n_bad++;
      $display("FAIL pulse_fall: got ok=%0d idx=%0d e=%b ts=%0d want 1 10 %0d", ok, out_idx, out_edge, out_ts, t2);
    end
    @(negedge clk);
    n_cmp++;
    if (6'(g2 - g1) !== 6'd3) begin
      n_bad++;
      $display("FAIL pulse_ts_delta: got %0d want 3", 6'(g2 - g1));
    end
  endtask

  task automatic test_same_cycle;
    logic [5:0] t;
    bit ok;
    en = 4'b1111; pos_sel = 4'b1111; neg_sel = 4'b0000; trg = 4'b0000;
    repeat (3) @(negedge clk);
    trg = 4'b1111; t = next_ts();
    for (int i = 0; i < 4; i++) begin
      wait_valid(ok);
      n_cmp++;
      if (!ok || {out_idx, out_edge, out_ts} !== {2'(i), EDGE_RISE, t}) begin
        n_bad++;
        $display("FAIL same_cycle_%0d: got ok=%0d idx=%0d e=%b ts=%0d want %0d 01 %0d",
                 i, ok, out_idx, out_edge, out_ts, i, t);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL same_cycle_drop: got %0d want 0", drop_cnt);
    end
  endtask

  task automatic test_overflow;
    logic [5:0] ts_q [20];
    logic [1:0] e;
    bit ok;
    en = 4'b0000; trg = 4'b0000;
    repeat (3) @(negedge clk);
    en = 4'b0001; pos_sel = 4'b0001; neg_sel = 4'b0001; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 20; j++) begin
      trg[0] = ~trg[0];
      ts_q[j] = next_ts();
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (drop_cnt !== 8'd11) begin
      n_bad++;
      $display("FAIL overflow_drop: got %0d want 11", drop_cnt);
    end
    n_cmp++;
    if ({out_valid, out_idx, out_edge, out_ts} !== {1'b1, 2'd0, EDGE_BOTH, ts_q[0]}) begin
      n_bad++;
      $display("FAIL overflow_head_hold: got v=%b idx=%0d e=%b ts=%0d want 1 0 11 %0d",
               out_valid, out_idx, out_edge, out_ts, ts_q[0]);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      e = (j % 2 == 0) ? EDGE_BOTH : EDGE_FALL;
      wait_valid(ok);
      n_cmp++;
      if (!ok || {out_idx, out_edge, out_ts} !== {2'd0, e, ts_q[j]}) begin
        n_bad++;
        $display("FAIL drain_%0d: got ok=%0d idx=%0d e=%b ts=%0d want 0 %b %0d",
                 j, ok, out_idx, out_edge, out_ts, e, ts_q[j]);
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_empty: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_wrap_and_reset;
    bit ok;
    for (int i = 0; i < 70 && (cyc % 64) != 62; i++) @(negedge clk);
    trg[0] = 1'b1;
    @(negedge clk);
    trg[0] = 1'b0;
    wait_valid(ok);
    n_cmp++;
    if (!ok || {out_edge, out_ts} !== {EDGE_BOTH, 6'd63}) begin
      n_bad++;
      $display("FAIL wrap_63: got ok=%0d e=%b ts=%0d want 11 63", ok, out_edge, out_ts);
    end
    @(negedge clk);
    wait_valid(ok);
    n_cmp++;
    if (!ok || {out_edge, out_ts} !== {EDGE_FALL, 6'd0}) begin
      n_bad++;
      $display("FAIL wrap_0: got ok=%0d e=%b ts=%0d want 10 0", ok, out_edge, out_ts);
    end
    @(negedge clk);
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      trg[0] = ~trg[0];
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL queued_before_reset: got valid=%b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, drop_cnt} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_flush: got valid=%b drop=%0d want 0 0", out_valid, drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_reprime: got valid=%b want 0", out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_check;
    logic [2:0] exp_f;
`ifdef EDGE_REC_CHECK_EN
    exp_f = 3'b110;
`else
    exp_f = 3'b000;
`endif
    en = 4'b0100; pos_sel = 4'b0100; neg_sel = 4'b0000; chk = 4'b0000;
    @(negedge clk);
    trg[2] = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({fail, fail_idx} !== exp_f) begin
      n_bad++;
      $display("FAIL check_first: got fail=%b idx=%0d want %b %0d", fail, fail_idx, exp_f[2], exp_f[1:0]);
    end
    chk = 4'b1111;
    trg[2] = 1'b0;
    @(negedge clk);
    trg[2] = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({fail, fail_idx} !== exp_f) begin
      n_bad++;
      $display("FAIL check_sticky: got fail=%b idx=%0d want %b %0d", fail, fail_idx, exp_f[2], exp_f[1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_pulse_both();
    test_same_cycle();
    test_overflow();
    test_wrap_and_reset();
    test_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
